debounce_multichannel: RTL and testbench

//  Parametrised N-channel debouncer / pulse stretcher for front-panel buttons, interlock and

---
 rtl/debounce_multichannel_pkg.sv | 15 +
 rtl/debounce_channel.sv | 98 +++++++++
 rtl/debounce_multichannel.sv | 38 +++
 tb/tb_debounce_multichannel.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_multichannel_pkg.sv
// Shared definitions for the multichannel debouncer:
// per-channel mode encodings and input normalisation.
package debounce_multichannel_pkg;

    localparam logic MODE_STRETCH = 1'b0;
    localparam logic MODE_FILTER  = 1'b1;

    function automatic logic normalise(
        input logic raw,
        input logic active_low
    );
        return raw ^ active_low;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: synchroniser, polarity normalise,
// stretch or filter counter, registered level and edge strobes.
module debounce_channel
    import debounce_multichannel_pkg::*;
#(
    parameter int   COUNTER_WIDTH = 8,
    parameter int   SYNC_STAGES   = 2,
    parameter logic ACTIVE_LOW    = 1'b1,
    parameter logic MODE          = MODE_STRETCH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     raw_in,
    input  logic [COUNTER_WIDTH-1:0] hold_cycles,
    output logic                     debounced,
    output logic                     rise_pulse,
    output logic                     fall_pulse
);

    logic                     raw_s;
    logic                     act;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     deb_q, deb_d;
    logic                     rise_q, rise_d;
    logic                     fall_q, fall_d;

    if (SYNC_STAGES > 0) begin : g_sync
        logic [SYNC_STAGES-1:0] sync_q, sync_d;

        always_comb begin
            sync_d[0] = raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_d[i] = sync_q[i-1];
            end
        end

        // Reset to the inactive level so release never looks like an edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
            end else begin
                sync_q <= sync_d;
            end
        end

        assign raw_s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
        assign raw_s = raw_in;
    end

    assign act = normalise(raw_s, ACTIVE_LOW);

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (MODE == MODE_FILTER) begin
            // >= covers a count left above a freshly lowered hold time.
            if (act == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q >= hold_cycles) begin
                deb_d = act;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + COUNTER_WIDTH'(1);
            end
        end else begin
            if (act) begin
                cnt_d = hold_cycles;
                deb_d = 1'b1;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - COUNTER_WIDTH'(1);
            end else begin
                deb_d = 1'b0;
            end
        end
        rise_d = deb_d & ~deb_q;
        fall_d = ~deb_d & deb_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign debounced  = deb_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/debounce_multichannel.sv
// N-channel debouncer / pulse stretcher; each channel gets its
// own polarity and mode bit sliced from the mask parameters.
module debounce_multichannel
    import debounce_multichannel_pkg::*;
#(
    parameter int                  CHANNELS         = 4,
    parameter int                  COUNTER_WIDTH    = 8,
    parameter int                  SYNC_STAGES      = 2,
    parameter logic [CHANNELS-1:0] INPUT_ACTIVE_LOW = {CHANNELS{1'b1}},
    parameter logic [CHANNELS-1:0] FILTER_MODE      = {CHANNELS{MODE_STRETCH}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      rawIn,
    input  logic [COUNTER_WIDTH-1:0] holdCycles,
    output logic [CHANNELS-1:0]      debounced,
    output logic [CHANNELS-1:0]      risePulse,
    output logic [CHANNELS-1:0]      fallPulse
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .SYNC_STAGES   (SYNC_STAGES),
            .ACTIVE_LOW    (INPUT_ACTIVE_LOW[i]),
            .MODE          (FILTER_MODE[i])
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .raw_in      (rawIn[i]),
            .hold_cycles (holdCycles),
            .debounced   (debounced[i]),
            .rise_pulse  (risePulse[i]),
            .fall_pulse  (fallPulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_multichannel.sv
// Bench for debounce_multichannel: directed scenarios plus random
// stimulus against a run-length / last-activity reference model.
module tb_debounce_multichannel;

    localparam int         CH   = 4;
    localparam int         CW   = 8;
    localparam logic [3:0] AL   = 4'b0101;
    localparam logic [3:0] FM   = 4'b1100;
    localparam logic [3:0] IDLE = AL;
    localparam logic [3:0] ACTV = ~AL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] rawIn = IDLE;
    logic [CW-1:0] holdCycles = 8'd10;
    logic [CH-1:0] debounced;
    logic [CH-1:0] risePulse;
    logic [CH-1:0] fallPulse;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [CH-1:0] p0 = '0;
    logic [CH-1:0] p1 = '0;
    logic [CH-1:0] e_deb = '0;
    logic [CH-1:0] e_rise = '0;
    logic [CH-1:0] e_fall = '0;
    int since [CH];
    int lh [CH];
    int run [CH];

    debounce_multichannel #(
        .CHANNELS         (CH),
        .COUNTER_WIDTH    (CW),
        .SYNC_STAGES      (2),
        .INPUT_ACTIVE_LOW (AL),
        .FILTER_MODE      (FM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rawIn      (rawIn),
        .holdCycles (holdCycles),
        .debounced  (debounced),
        .risePulse  (risePulse),
        .fallPulse  (fallPulse)
    );

    always #5 clk = ~clk;

    // Stretch: high while the last active sample is within its hold time.
    // Filter: adopt when the run of differing samples exceeds hold.
    task automatic model_step();
        logic act;
        logic nd;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                p0[c] = 1'b0;
                p1[c] = 1'b0;
                e_deb[c] = 1'b0;
                e_rise[c] = 1'b0;
                e_fall[c] = 1'b0;
                since[c] = 100000;
                lh[c] = 0;
                run[c] = 0;
            end else begin
                act = p1[c];
                p1[c] = p0[c];
                p0[c] = rawIn[c] ^ AL[c];
                nd = e_deb[c];
                if (FM[c]) begin
                    if (act == e_deb[c]) begin
                        run[c] = 0;
                    end else begin
                        run[c]++;
                        if (run[c] >= int'(holdCycles) + 1) begin
                            nd = act;
                            run[c] = 0;
                        end
                    end
                end else begin
                    if (act) begin
                        since[c] = 0;
                        lh[c] = int'(holdCycles);
                    end else if (since[c] < 100000) begin
                        since[c]++;
                    end
                    nd = (since[c] <= lh[c]);
                end
                e_rise[c] = nd & ~e_deb[c];
                e_fall[c] = ~nd & e_deb[c];
                e_deb[c] = nd;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rawIn = IDLE;
        repeat (3) tick();
        tests++;
        if ({debounced, risePulse, fallPulse} !== 12'h000) begin
            fails++;
            $display("FAIL reset_hold got %h want 000",
                     {debounced, risePulse, fallPulse});
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            tests++;
            if ({debounced, risePulse, fallPulse} !== 12'h000) begin
                fails++;
                $display("FAIL reset_release cyc %0d got %h want 000",
                         k, {debounced, risePulse, fallPulse});
            end
        end
    endtask

    task automatic test_stretch();
        int rc, fc, nr, nf, high;
        holdCycles = 8'd10;
        rawIn = IDLE;
        repeat (5) tick();
        rc = 0; fc = 0; nr = 0; nf = 0; high = 0;
        rawIn[0] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) rawIn[0] = 1'b1;
            if (risePulse[0]) begin nr++; rc = k; end
            if (fallPulse[0]) begin nf++; fc = k; end
            if (debounced[0]) high++;
        end
        tests++;
        if (rc != 3 || nr != 1) begin
            fails++;
            $display("FAIL stretch_rise at %0d x%0d want 3 x1", rc, nr);
        end
        tests++;
        if (high != 11) begin
            fails++;
            $display("FAIL stretch_len got %0d want 11", high);
        end
        tests++;
        if (fc != 14 || nf != 1) begin
            fails++;
            $display("FAIL stretch_fall at %0d x%0d want 14 x1", fc, nf);
        end
    endtask

    task automatic test_retrigger();
        int rc, fc, nr, nf, high;
        logic h [1:40];
        rawIn = IDLE;
        repeat (15) tick();
        rc = 0; fc = 0; nr = 0; nf = 0; high = 0;
        rawIn[0] = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            rawIn[0] = (k == 6) ? 1'b0 : 1'b1;
            if (risePulse[0]) begin nr++; rc = k; end
            if (fallPulse[0]) begin nf++; fc = k; end
            if (debounced[0]) high++;
        end
        tests++;
        if (rc != 3 || nr != 1 || fc != 20 || nf != 1 || high != 17) begin
            fails++;
            $display("FAIL retrigger got r%0dx%0d f%0dx%0d h%0d want r3x1 f20x1 h17",
                     rc, nr, fc, nf, high);
        end
        holdCycles = 8'd0;
        for (int k = 1; k <= 40; k++) begin
            h[k] = 1'($urandom_range(0, 1));
            rawIn[0] = h[k];
            tick();
            if (k >= 3) begin
                tests++;
                if (debounced[0] !== ~h[k-2]) begin
                    fails++;
                    $display("FAIL hold0_copy cyc %0d got %b want %b",
                             k, debounced[0], ~h[k-2]);
                end
            end
        end
        rawIn = IDLE;
        repeat (5) tick();
    endtask

    task automatic test_filter();
        int rc, fc, nr, nf, high;
        holdCycles = 8'd4;
        rawIn = IDLE;
        repeat (10) tick();
        nr = 0; high = 0;
        for (int k = 1; k <= 20; k++) begin
            rawIn[3] = (k <= 4);
            tick();
            if (risePulse[3]) nr++;
            if (debounced[3]) high++;
        end
        tests++;
        if (nr != 0 || high != 0) begin
            fails++;
            $display("FAIL filter_glitch rises %0d high %0d want 0 0", nr, high);
        end
        rc = 0; nr = 0;
        rawIn[3] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (risePulse[3]) begin nr++; rc = k; end
        end
        tests++;
        if (rc != 7 || nr != 1 || debounced[3] !== 1'b1) begin
            fails++;
            $display("FAIL filter_rise at %0d x%0d lvl %b want 7 x1 1",
                     rc, nr, debounced[3]);
        end
        fc = 0; nf = 0;
        rawIn[3] = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (fallPulse[3]) begin nf++; fc = k; end
        end
        tests++;
        if (fc != 7 || nf != 1 || debounced[3] !== 1'b0) begin
            fails++;
            $display("FAIL filter_fall at %0d x%0d lvl %b want 7 x1 0",
                     fc, nf, debounced[3]);
        end
    endtask

    task automatic test_mid_count();
        holdCycles = 8'd20;
        rawIn[3] = 1'b1;
        repeat (12) tick();
        tests++;
        if (debounced[3] !== 1'b0) begin
            fails++;
            $display("FAIL midcount_pre got %b want 0", debounced[3]);
        end
        holdCycles = 8'd3;
        tick();
        tests++;
        if (risePulse[3] !== 1'b1 || debounced[3] !== 1'b1) begin
            fails++;
            $display("FAIL midcount_adopt rise %b lvl %b want 1 1",
                     risePulse[3], debounced[3]);
        end
        rawIn = IDLE;
        repeat (12) tick();
    endtask

    task automatic test_simultaneous();
        logic [3:0] r3, r9;
        holdCycles = 8'd6;
        rawIn = ACTV;
        r3 = '0;
        r9 = '0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 8) rawIn = IDLE;
            if (k == 3) r3 = risePulse;
            if (k == 9) r9 = risePulse;
        end
        tests++;
        if (r3 !== 4'b0011 || r9 !== 4'b1100) begin
            fails++;
            $display("FAIL simul_rise got %b/%b want 0011/1100", r3, r9);
        end
        tests++;
        if (debounced !== 4'hf) begin
            fails++;
            $display("FAIL simul_level got %b want 1111", debounced);
        end
        rst = 1'b1;
        tick();
        tests++;
        if ({debounced, risePulse, fallPulse} !== 12'h000) begin
            fails++;
            $display("FAIL midhold_rst got %h want 000",
                     {debounced, risePulse, fallPulse});
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            tests++;
            if ({debounced, risePulse, fallPulse} !== 12'h000) begin
                fails++;
                $display("FAIL post_rst cyc %0d got %h want 000",
                         k, {debounced, risePulse, fallPulse});
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] r;
        r = IDLE;
        for (int k = 0; k < 20000; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 7) == 0) r[c] = ~r[c];
            end
            rawIn = r;
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 199) == 0) begin
                holdCycles = CW'($urandom_range(0, 12));
            end
            tick();
            tests++;
            if (debounced !== e_deb || risePulse !== e_rise ||
                fallPulse !== e_fall) begin
                fails++;
                $display("FAIL random cyc %0d d/r/f got %b/%b/%b want %b/%b/%b",
                         k, debounced, risePulse, fallPulse,
                         e_deb, e_rise, e_fall);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            since[c] = 100000;
            lh[c] = 0;
            run[c] = 0;
        end
        test_reset();
        test_stretch();
        test_retrigger();
        test_filter();
        test_mid_count();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
